// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared types and helpers for the SAR conversion controller.
//   sar_state_e      : controller FSM state encoding
//   idx_w()          : index width for a count of N items, never below 1 bit
//   msb_first_code() : first trial code of a conversion (MSB set, rest zero)
// ---------------------------------------------------------------------------
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Returned 32 bits wide; callers cast down to their own WIDTH.
  function automatic logic [31:0] msb_first_code(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// ---------------------------------------------------------------------------
// sar_bit_engine
// Successive-approximation bit search. Owns the trial code register and the
// bit pointer.
//   clk, reset         : clock, synchronous active-high reset
//   load_i             : start a search (code = 100..0, pointer = MSB)
//   step_i             : resolve the bit under the pointer from comparator_out_i
//   comparator_out_i   : 1 = input >= DAC(code_o)
//   code_o             : current trial code (drives the DAC)
//   code_next_o        : code after this cycle's load/step (final code when the
//                        last bit resolves)
//   last_bit_o         : pointer is at bit 0
// ---------------------------------------------------------------------------
module sar_bit_engine
  import sar_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PTR_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             comparator_out_i,
  output logic [WIDTH-1:0] code_o,
  output logic [WIDTH-1:0] code_next_o,
  output logic             last_bit_o
);

  logic [WIDTH-1:0] code_q, code_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    code_d = code_q;
    ptr_d  = ptr_q;
    if (load_i) begin
      code_d = WIDTH'(msb_first_code(WIDTH));
      ptr_d  = PTR_W'(WIDTH - 1);
    end else if (step_i) begin
      code_d[ptr_q] = comparator_out_i;
      // Pointer stops at 0; the caller decodes last_bit_o to leave CONVERT.
      if (ptr_q != '0) begin
        code_d[ptr_q - PTR_W'(1)] = 1'b1;
        ptr_d = ptr_q - PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
      ptr_q  <= '0;
    end else begin
      code_q <= code_d;
      ptr_q  <= ptr_d;
    end
  end

  assign code_o      = code_q;
  assign code_next_o = code_d;
  assign last_bit_o  = (ptr_q == '0);

endmodule

// File: rtl/sar_conversion_controller.sv
// ---------------------------------------------------------------------------
// sar_conversion_controller
// SAR ADC digital back-end: accepts a start with channel select, holds the
// track window for SAMPLE_CYCLES, resolves WIDTH bits MSB-first through
// sar_bit_engine and presents the result on a valid/ready output.
//
// Optional build macro: SAR_OFFSET_TRIM_EN
//   adds offset_trim_i (signed); result = code - trim, saturated to
//   [0, 2^WIDTH-1], folded into the DONE load so latency is unchanged.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start_i, ch_sel_i : conversion request and its channel (IDLE only)
//   comparator_out_i  : 1 = Vin >= DAC(dac_code_o)
//   mux_sel_o         : registered analog mux select
//   sample_en_o       : track/hold, high = track
//   dac_code_o        : trial code to the DAC
//   busy_o            : high outside IDLE
//   result_valid_o/result_ready_i/result_data_o/result_ch_o : result handshake
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_SAMPLE  | tracking input, SAMPLE_CYCLES cycles
// ST_CONVERT | resolving one bit per cycle, MSB first
// ST_DONE    | result valid, waiting for result_ready_i
// ---------------------------------------------------------------------------
module sar_conversion_controller
  import sar_pkg::*;
#(
  parameter  int WIDTH         = 8,
  parameter  int NUM_CH        = 4,
  parameter  int SAMPLE_CYCLES = 2,
  localparam int CH_W          = idx_w(NUM_CH),
  localparam int SCNT_W        = idx_w(SAMPLE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [CH_W-1:0]  ch_sel_i,
  input  logic             comparator_out_i,
  input  logic             result_ready_i,
`ifdef SAR_OFFSET_TRIM_EN
  input  logic [WIDTH-1:0] offset_trim_i,
`endif
  output logic [CH_W-1:0]  mux_sel_o,
  output logic             sample_en_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_data_o,
  output logic [CH_W-1:0]  result_ch_o
);

  sar_state_e        state_q, state_d;
  logic [SCNT_W-1:0] samp_cnt_q;
  logic [CH_W-1:0]   mux_sel_q, result_ch_q;
  logic [WIDTH-1:0]  result_data_q;
  logic [CH_W-1:0]   ch_clamped;
  logic [WIDTH-1:0]  code_next, final_code;
  logic              last_bit;
  logic              accept, eng_load, eng_step;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i)           state_d = ST_SAMPLE;
      ST_SAMPLE:  if (samp_cnt_q == '0)  state_d = ST_CONVERT;
      ST_CONVERT: if (last_bit)          state_d = ST_DONE;
      ST_DONE:    if (result_ready_i)    state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    sample_en_o    = (state_q == ST_SAMPLE);
    busy_o         = (state_q != ST_IDLE);
    result_valid_o = (state_q == ST_DONE);
    accept         = (state_q == ST_IDLE) && start_i;
    eng_load       = (state_q == ST_SAMPLE) && (samp_cnt_q == '0);
    eng_step       = (state_q == ST_CONVERT);
  end

  // Out-of-range channels map to the highest channel.
  always_comb begin
    if (int'(ch_sel_i) >= NUM_CH) ch_clamped = CH_W'(NUM_CH - 1);
    else                          ch_clamped = ch_sel_i;
  end

  // Down-counter loaded on accept; SAMPLE exits when it reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_cnt_q <= '0;
    end else if (accept) begin
      samp_cnt_q <= SCNT_W'(SAMPLE_CYCLES - 1);
    end else if ((state_q == ST_SAMPLE) && (samp_cnt_q != '0)) begin
      samp_cnt_q <= samp_cnt_q - SCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_sel_q   <= '0;
      result_ch_q <= '0;
    end else if (accept) begin
      mux_sel_q   <= ch_clamped;
      result_ch_q <= ch_clamped;
    end
  end

  sar_bit_engine #(.WIDTH(WIDTH)) u_bit_engine (
    .clk              (clk),
    .reset            (reset),
    .load_i           (eng_load),
    .step_i           (eng_step),
    .comparator_out_i (comparator_out_i),
    .code_o           (dac_code_o),
    .code_next_o      (code_next),
    .last_bit_o       (last_bit)
  );

`ifdef SAR_OFFSET_TRIM_EN
  // Unsigned code minus sign-extended trim in WIDTH+2 bits: bit WIDTH+1 flags
  // a negative result, bit WIDTH an overflow above full scale.
  logic [WIDTH+1:0] trim_diff;
  always_comb begin
    trim_diff = {2'b00, code_next} - {{2{offset_trim_i[WIDTH-1]}}, offset_trim_i};
    if (trim_diff[WIDTH+1])  final_code = '0;
    else if (trim_diff[WIDTH]) final_code = '1;
    else                     final_code = trim_diff[WIDTH-1:0];
  end
`else
  assign final_code = code_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_data_q <= '0;
    end else if (eng_step && last_bit) begin
      result_data_q <= final_code;
    end
  end

  assign mux_sel_o     = mux_sel_q;
  assign result_ch_o   = result_ch_q;
  assign result_data_o = result_data_q;

endmodule

// File: tb/tb_sar_conversion_controller.sv
// Directed bench for sar_conversion_controller (WIDTH=8, NUM_CH=4, S=2).
// Comparator is modelled as Vin >= dac_code, or forced to a constant.
module tb_sar_conversion_controller;

  localparam int W  = 8;
  localparam int S  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [1:0] ch_sel_i;
  logic       comparator_out_i;
  logic       result_ready_i;
  logic [7:0] offset_trim_i;
  logic [1:0] mux_sel_o;
  logic       sample_en_o;
  logic [7:0] dac_code_o;
  logic       busy_o;
  logic       result_valid_o;
  logic [7:0] result_data_o;
  logic [1:0] result_ch_o;

  logic [7:0] vin;
  logic       force_en;
  logic       force_val;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign comparator_out_i = force_en ? force_val : (vin >= dac_code_o);

  sar_conversion_controller #(
    .WIDTH(8), .NUM_CH(4), .SAMPLE_CYCLES(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .ch_sel_i         (ch_sel_i),
    .comparator_out_i (comparator_out_i),
    .result_ready_i   (result_ready_i),
`ifdef SAR_OFFSET_TRIM_EN
    .offset_trim_i    (offset_trim_i),
`endif
    .mux_sel_o        (mux_sel_o),
    .sample_en_o      (sample_en_o),
    .dac_code_o       (dac_code_o),
    .busy_o           (busy_o),
    .result_valid_o   (result_valid_o),
    .result_data_o    (result_data_o),
    .result_ch_o      (result_ch_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".sample_en"}, 32'(sample_en_o), 0);
    chk({tag, ".dac_code"}, 32'(dac_code_o), 0);
    chk({tag, ".busy"}, 32'(busy_o), 0);
    chk({tag, ".valid"}, 32'(result_valid_o), 0);
    chk({tag, ".data"}, 32'(result_data_o), 0);
    chk({tag, ".ch"}, 32'(result_ch_o), 0);
    chk({tag, ".mux_sel"}, 32'(mux_sel_o), 0);
  endtask

  // Drive start for one edge (edge k); returns at the negedge of cycle k+1.
  task automatic issue_start(input logic [1:0] ch);
    @(negedge clk);
    start_i  = 1'b1;
    ch_sel_i = ch;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  // Expected trial code while bit i is under test: bits above i from the
  // reference value, bit i set, lower bits clear.
  function automatic logic [7:0] trial(input logic [7:0] ref_v, input int i);
    logic [7:0] keep;
    keep = ~8'((1 << (i + 1)) - 1);
    return (ref_v & keep) | 8'(1 << i);
  endfunction

  // Full conversion; returns at the negedge of the first DONE cycle.
  task automatic run_conv(input string tag, input logic [1:0] ch, input logic [7:0] v,
                          input logic fe, input logic fv,
                          input logic [7:0] exp_data, input logic [1:0] exp_ch);
    logic [7:0] ref_v;
    vin       = v;
    force_en  = fe;
    force_val = fv;
    ref_v     = fe ? {8{fv}} : v;
    issue_start(ch);
    chk({tag, ".mux_sel"}, 32'(mux_sel_o), 32'(exp_ch));
    for (int s = 0; s < S; s++) begin
      chk({tag, ".sample_en_hi"}, 32'(sample_en_o), 1);
      chk({tag, ".busy_sample"}, 32'(busy_o), 1);
      @(negedge clk);
    end
    for (int j = 0; j < W; j++) begin
      chk({tag, ".dac_code"}, 32'(dac_code_o), 32'(trial(ref_v, W - 1 - j)));
      chk({tag, ".sample_en_lo"}, 32'(sample_en_o), 0);
      chk({tag, ".valid_early"}, 32'(result_valid_o), 0);
      @(negedge clk);
    end
    // cycle k+S+W+1
    chk({tag, ".valid"}, 32'(result_valid_o), 1);
    chk({tag, ".data"}, 32'(result_data_o), 32'(exp_data));
    chk({tag, ".ch"}, 32'(result_ch_o), 32'(exp_ch));
    chk({tag, ".busy_done"}, 32'(busy_o), 1);
    chk({tag, ".dac_final"}, 32'(dac_code_o), 32'(ref_v));
  endtask

  task automatic ack(input string tag);
    result_ready_i = 1'b1;
    @(negedge clk);
    result_ready_i = 1'b0;
    chk({tag, ".valid_after_ack"}, 32'(result_valid_o), 0);
    chk({tag, ".busy_after_ack"}, 32'(busy_o), 0);
  endtask

  initial begin
    logic [2:0] wide_ch;
    reset          = 1'b1;
    start_i        = 1'b0;
    ch_sel_i       = 2'd0;
    result_ready_i = 1'b0;
    offset_trim_i  = 8'd0;
    vin            = 8'd0;
    force_en       = 1'b0;
    force_val      = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset = 1'b0;

    // Basic conversion, Vin = 0xA5 on channel 2
    run_conv("vin_a5", 2'd2, 8'hA5, 1'b0, 1'b0, 8'hA5, 2'd2);
    ack("vin_a5");

    // Constant comparator outputs
    run_conv("cmp_one", 2'd1, 8'h00, 1'b1, 1'b1, 8'hFF, 2'd1);
    ack("cmp_one");
    run_conv("cmp_zero", 2'd0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0);
    ack("cmp_zero");

    // Back-pressure: ready low 5 cycles, start pulses ignored
    run_conv("hold", 2'd3, 8'h5A, 1'b0, 1'b0, 8'h5A, 2'd3);
    for (int c = 0; c < 5; c++) begin
      start_i  = 1'b1;
      ch_sel_i = 2'd1;
      @(negedge clk);
      start_i  = 1'b0;
      chk("hold.valid", 32'(result_valid_o), 1);
      chk("hold.data", 32'(result_data_o), 32'h5A);
      chk("hold.ch", 32'(result_ch_o), 3);
      chk("hold.busy", 32'(busy_o), 1);
      chk("hold.mux_sel", 32'(mux_sel_o), 3);
    end
    // start together with the handshake edge must not be taken
    start_i = 1'b1;
    ack("hold");
    start_i = 1'b0;
    @(negedge clk);
    chk("hold.no_queue_busy", 32'(busy_o), 0);

    // Reset while resolving bit 4 of Vin = 0xA5
    vin      = 8'hA5;
    force_en = 1'b0;
    issue_start(2'd2);
    repeat (S + 3) @(negedge clk);
    chk("rst_mid.dac_bit4", 32'(dac_code_o), 32'hB0);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    reset = 1'b0;
    run_conv("after_rst", 2'd1, 8'h3C, 1'b0, 1'b0, 8'h3C, 2'd1);
    ack("after_rst");

    // Channel select wider than the port: upper bit is dropped, lands on 3
    wide_ch = 3'd7;
    run_conv("ch7", wide_ch[1:0], 8'h33, 1'b0, 1'b0, 8'h33, 2'd3);
    ack("ch7");

    // Back-to-back channel sweep
    run_conv("ch0", 2'd0, 8'h11, 1'b0, 1'b0, 8'h11, 2'd0);
    ack("ch0");
    run_conv("ch1", 2'd1, 8'h7F, 1'b0, 1'b0, 8'h7F, 2'd1);
    ack("ch1");
    run_conv("ch2", 2'd2, 8'h80, 1'b0, 1'b0, 8'h80, 2'd2);
    ack("ch2");
    run_conv("ch3", 2'd3, 8'hE6, 1'b0, 1'b0, 8'hE6, 2'd3);
    ack("ch3");

`ifdef SAR_OFFSET_TRIM_EN
    offset_trim_i = 8'h08;
    run_conv("trim_low_sat", 2'd0, 8'h05, 1'b0, 1'b0, 8'h00, 2'd0);
    ack("trim_low_sat");
    offset_trim_i = 8'hF8;
    run_conv("trim_high_sat", 2'd1, 8'hFC, 1'b0, 1'b0, 8'hFF, 2'd1);
    ack("trim_high_sat");
    offset_trim_i = 8'h04;
    run_conv("trim_mid", 2'd2, 8'h40, 1'b0, 1'b0, 8'h3C, 2'd2);
    ack("trim_mid");
    offset_trim_i = 8'h00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_conversion_controller.md
Name: sar_conversion_controller

Overview:
Parametrised successive-approximation controller for the SAR ADC digital back-end. It accepts a start request with a channel select and drives the sample/hold window and the trial DAC code. It then resolves WIDTH bits MSB-first from the comparator and presents the result on a valid/ready output. It sits between the sequencer/bus interface and the analog DAC/comparator macro, and adds multi-channel, sample timing and back-pressure on top of the basic bit-search.

Parameters:
WIDTH, 8, conversion resolution in bits (>=2)
NUM_CH, 4, number of analog input channels (>=1)
SAMPLE_CYCLES, 2, cycles sample_en is held high before conversion (>=1)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  conversion request; accepted only when busy=0
ch_sel  input  max(1,$clog2(NUM_CH))  channel for the request, captured with start
comparator_out  input  1  1 = Vin >= DAC(dac_code)
mux_sel  output  max(1,$clog2(NUM_CH))  registered analog mux select
sample_en  output  1  track/hold control, high = track
dac_code  output  WIDTH  trial code to DAC
busy  output  1  high in every state except IDLE
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
result_data  output  WIDTH  converted code
result_ch  output  max(1,$clog2(NUM_CH))  channel of result_data

Behaviour:
- Reset values: state IDLE, sample_en=0, dac_code=0, busy=0, result_valid=0, result_data=0, result_ch=0, mux_sel=0.
- FSM states (shared enum): IDLE, SAMPLE, CONVERT, DONE.
- IDLE: when start=1 at edge k, capture ch_sel into mux_sel/result_ch, go to SAMPLE.
- IDLE: ch_sel >= NUM_CH is clamped to NUM_CH-1.
- SAMPLE: sample_en=1 for exactly SAMPLE_CYCLES cycles (k+1..k+S), counted by a sample counter. Then go to CONVERT with dac_code = 1 followed by WIDTH-1 zeros.
- CONVERT: WIDTH cycles; bit pointer i runs WIDTH-1 down to 0. Each cycle comparator_out is sampled against the current dac_code.
  - Bit i is kept if comparator_out=1, otherwise cleared.
  - If i>0, bit i-1 is set to 1.
  - When i=0 resolves, the final code is loaded into result_data, dac_code holds the final code, and the FSM goes to DONE.
- Latency: start at edge k, result_valid=1 from cycle k+SAMPLE_CYCLES+WIDTH+1.
- DONE: result_valid=1. result_data and result_ch stay stable until result_valid && result_ready. That handshake returns to IDLE with result_valid=0 on the next cycle.
- DONE to next start: a new start is accepted no earlier than the IDLE cycle after the handshake. start while busy=1 is ignored (not queued).
- Bit pointer width: max(1,$clog2(WIDTH)). It does not wrap below 0; the CONVERT exit is decoded at i=0.
- Reset mid-operation (any state) returns to reset values on the next edge and discards any partial result.
- Comparator all-1 gives result 2^WIDTH-1; all-0 gives 0.

Optional Feature:
Macro SAR_OFFSET_TRIM_EN.
- Defined: adds input port offset_trim [WIDTH] (signed, two's complement). result_data = final code minus offset_trim, saturated to [0, 2^WIDTH-1], computed in WIDTH+2 bits. Latency is unchanged (subtraction is folded into the DONE load).
- Undefined: no port; result_data = raw code.

Decomposition:
- Package sar_pkg holds:
  - the state enum (IDLE/SAMPLE/CONVERT/DONE)
  - a helper function for the channel index width
  - the MSB-first initial-code constant function
- Sub-module sar_bit_engine: load/step inputs, comparator_out, outputs code, last_bit. It owns the code register and bit pointer.
- The top level holds the FSM, sample counter, channel capture, output handshake and optional trim.

Test Plan:
- WIDTH=8, S=2; start ch=2, comparator models Vin=0xA5 (out = 0xA5>=dac_code) -> sample_en high 2 cycles, result_valid at k+11, result_data=0xA5, result_ch=2.
- Comparator constant 1, then constant 0 -> results 0xFF and 0x00; dac_code sequence 80,C0,E0…FF and 80,40,20…01.
- result_ready held low 5 cycles after valid -> data/ch stable and busy=1 throughout; start pulses during hold ignored; ready=1 returns to IDLE next cycle.
- Reset asserted in CONVERT at bit 4 -> next cycle all outputs at reset values; a fresh start converts Vin=0x3C correctly.
- ch_sel=7 with NUM_CH=4 -> mux_sel=3, result_ch=3; back-to-back conversions ch0..ch3 give independent correct results.
- SAR_OFFSET_TRIM_EN, Vin=0x05, trim=+8 -> 0x00 (saturate); Vin=0xFC, trim=-8 -> 0xFF; Vin=0x40, trim=+4 -> 0x3C.
